des_round_engine: RTL and testbench
===================================

// Module: des_round_engine
// PURPOSE
// Iterative 16-round DES Feistel core, one round per clock. It accepts an
// initial-permuted 64-bit block and a PC-1-reduced 56-bit key, and generates
// round subkeys on the fly (C/D rotation plus PC-2).
// It returns the swapped preoutput {R16,L16} that drives the inverse-permutation
// stage directly. Encrypt and decrypt are selectable per block.
// PARAMETERS
// NUM_ROUNDS  16  round count; fixed at 16 for DES, kept only for reduced-round debug builds
// PORTS
// clk          in   1   rising-edge clock
// rst_n        in   1   asynchronous active-low reset
// in_valid     in   1   block/key/mode offered
// in_ready     out  1   engine can accept (IDLE only)
// in_block     in   64  IP output; [31:0]=L0, [63:32]=R0; bit [0] = DES bit 1
// in_key       in   56  PC-1 output; [27:0]=C0, [55:28]=D0; bit [0] = DES bit 1
// in_decrypt   in   1   0=encrypt, 1=decrypt; sampled at accept
// out_valid    out  1   result held
// out_ready    in   1   downstream accepts result
// last_round_output  out  64  [31:0]=R16, [63:32]=L16 (preoutput, swap applied)
// round_idx    out  4   current round minus 1 (debug); 0 when idle
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0;
//   last_round_output=0; round_idx=0; internal L/R/C/D/mode=0.
// - FSM states: IDLE -> ROUND on in_valid&&in_ready. ROUND -> DONE when round 16 is
//   written. DONE -> IDLE on out_ready. There are no other transitions.
// - Accept edge E0: latch L,R from in_block, C,D from in_key, mode from in_decrypt;
//   counter=0.
// - Rounds: edge Ek (k=1..16) performs round k.
//   L'=R, R'=L^f(R,Kk), where Kk=PC2(Ck,Dk).
//   After E16: state=DONE, out_valid=1, last_round_output={L16,R16} per the
//   bit map above. No swap is applied at round 16 beyond the preoutput ordering.
// - Latency: out_valid rises the cycle after E16, i.e. 16 clocks after the accept edge.
// - Key schedule, encrypt: before round k, rotate C,D left by S[k].
//   S = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
//   In this bit order, rotate-left is new[i]=old[(i+s)%28].
// - Key schedule, decrypt: round 1 uses the unrotated C0,D0. Before round k>1,
//   rotate right by S[18-k] (sequence 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
//   new[i]=old[(i-s+28)%28].
// - Handshake: in_ready=1 only in IDLE. in_valid is ignored in ROUND and DONE.
//   There is no accept in the same cycle DONE->IDLE, so in_ready rises the cycle
//   after the output transfer. Minimum period is 18 clocks per block.
// - DONE holds last_round_output and out_valid stable until out_ready=1. The result
//   register is not updated while busy with the next block; it changes only at E16.
// - in_decrypt change after accept has no effect. in_block/in_key need to be valid
//   only in the accept cycle.
// - round_idx = counter during ROUND, 15 in DONE, 0 in IDLE.
// - Reset mid-operation: aborts immediately and returns to the reset values above.
//   No partial result is ever flagged valid.
// STRUCTURE
// - Shared package des_pkg:
//   - SHIFT_SCHEDULE[16] constant
//   - PC2 table and E table (48 entries each)
//   - P table
//   - rotate_left28/rotate_right28 functions
//   - state enum {IDLE,ROUND,DONE}
// - Sub-module des_f_function: combinational; ports r[31:0], k[47:0], f[31:0].
//   Contains E expansion, key XOR, S1-S8 and P.
// - The engine holds the FSM, 4-bit round counter, L/R/C/D registers, PC-2 wiring
//   and the output register.
// TESTING
// - Wrap the engine with the team IP and inverse-permutation blocks plus a PC-1
//   bench model.
// - Encrypt vector: key 133457799BBCDFF1, pt 0123456789ABCDEF.
//   Required: L16=43423234, R16=0A4CD995 (DES bit order); wrapped output
//   85E813540F0AB405. out_valid 16 clocks after accept.
// - Decrypt the same key, ct 85E813540F0AB405 -> 0123456789ABCDEF.
//   Plus 200 random key/pt pairs, each encrypt then decrypt; the round trip must be
//   exact against a C reference model.
// - Backpressure: hold out_ready=0 for 5 cycles in DONE.
//   Required: out_valid=1 and output constant; in_ready=0 throughout; accept
//   possible again 1 cycle after out_ready.
// - Busy ignore: pulse in_valid with a different block during rounds 3-10.
//   Required: result unchanged from the first-block expected value.
// - Reset mid-round: assert rst_n=0 asynchronously at round_idx=6.
//   Required: out_valid=0, in_ready=1, round_idx=0 with no clock edge. After
//   release, a fresh FIPS block yields the correct result.
// - Mode latch: set in_decrypt=1 at accept, then 0 from the next cycle.
//   Required: the output matches a decrypt result.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants for the round engine: state encoding, key-schedule
// shifts, PC-2 / E / P tables (1-based DES bit numbers) and 28-bit rotations.
package des_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_e;

    localparam int SHIFT_SCHEDULE [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int E_TABLE [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_TABLE [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Bit 0 is DES bit 1, so a DES left rotation moves bits toward index 0.
    function automatic logic [27:0] rotate_left28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    function automatic logic [27:0] rotate_right28(input logic [27:0] x, input logic [1:0] s);
        return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

endpackage

// File: rtl/des_f_function.sv
// DES round function f(R,K): E expansion, subkey XOR, S1-S8 and P.
// Purely combinational; bit 0 of every vector is DES bit 1.
module des_f_function
    import des_pkg::*;
(
    input  logic [31:0] r,
    input  logic [47:0] k,
    output logic [31:0] f
);

    localparam int SBOX [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}
    };

    logic [47:0] e;
    logic [47:0] x;
    logic [31:0] s_out;

    for (genvar j = 0; j < 48; j++) begin : g_expand
        assign e[j] = r[E_TABLE[j] - 1];
    end

    assign x = e ^ k;

    // Six-bit group: first bit and last bit pick the row, middle four the column;
    // the first S-box output bit is the MSB of the table value.
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        logic [5:0] six;
        logic [3:0] val;
        assign six = x[6*g +: 6];
        assign val = 4'(SBOX[g][{six[0], six[5], six[1], six[2], six[3], six[4]}]);
        assign s_out[4*g +: 4] = {val[0], val[1], val[2], val[3]};
    end

    for (genvar j = 0; j < 32; j++) begin : g_perm
        assign f[j] = s_out[P_TABLE[j] - 1];
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: one round per clock, subkeys derived on the fly
// from rotating C/D registers; returns the swapped preoutput {L16,R16}.
module des_round_engine
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_block,
    input  logic [55:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] last_round_output,
    output logic [3:0]  round_idx
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

    state_e      state_q, state_d;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic        mode_q;
    logic [3:0]  count_q;
    logic [63:0] result_q;

    logic        accept, round_en, last_round;
    logic [3:0]  dec_idx;
    logic [1:0]  shift_amt;
    logic [27:0] c_k, d_k;
    logic [47:0] subkey;
    logic [31:0] f_out, r_next;

    // A transfer happens on any edge where valid and ready are both high; input
    // is taken only in IDLE, and the result is held in DONE until out_ready.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        round_idx  = 4'd0;
        accept     = 1'b0;
        round_en   = 1'b0;
        last_round = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                round_en  = 1'b1;
                round_idx = count_q;
                if (count_q == LAST_IDX) begin
                    last_round = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                round_idx = LAST_IDX;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Decrypt walks the schedule backwards: round 1 uses C0/D0 unrotated.
    assign dec_idx = 4'(5'd16 - {1'b0, count_q});

    always_comb begin
        shift_amt = mode_q ? 2'(SHIFT_SCHEDULE[dec_idx]) : 2'(SHIFT_SCHEDULE[count_q]);
        c_k = rotate_left28(c_q, shift_amt);
        d_k = rotate_left28(d_q, shift_amt);
        if (mode_q) begin
            if (count_q == 4'd0) begin
                c_k = c_q;
                d_k = d_q;
            end else begin
                c_k = rotate_right28(c_q, shift_amt);
                d_k = rotate_right28(d_q, shift_amt);
            end
        end
    end

    for (genvar j = 0; j < 48; j++) begin : g_pc2
        if (PC2_TABLE[j] <= 28) begin : g_c
            assign subkey[j] = c_k[PC2_TABLE[j] - 1];
        end else begin : g_d
            assign subkey[j] = d_k[PC2_TABLE[j] - 29];
        end
    end

    des_f_function u_f (
        .r (r_q),
        .k (subkey),
        .f (f_out)
    );

    assign r_next = l_q ^ f_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            mode_q   <= 1'b0;
            count_q  <= '0;
            result_q <= '0;
        end else if (accept) begin
            l_q     <= in_block[31:0];
            r_q     <= in_block[63:32];
            c_q     <= in_key[27:0];
            d_q     <= in_key[55:28];
            mode_q  <= in_decrypt;
            count_q <= '0;
        end else if (round_en) begin
            l_q <= r_q;
            r_q <= r_next;
            c_q <= c_k;
            d_q <= d_k;
            if (last_round) result_q <= {r_q, r_next};
            else            count_q  <= count_q + 4'd1;
        end
    end

    assign last_round_output = result_q;

endmodule

// File: tb/tb_des_round_engine.sv
// Bench for des_round_engine: wraps the core with IP, PC-1 and IP^-1 and checks
// it against a full FIPS-order DES reference model.
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_block;
    logic [55:0] in_key;
    logic        in_decrypt;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] last_round_output;
    logic [3:0]  round_idx;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    localparam logic [63:0] FIPS_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] FIPS_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] FIPS_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] FIPS_PRE = 64'h0A4CD995_43423234;

    always #5 clk = ~clk;

    des_round_engine dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_block          (in_block),
        .in_key            (in_key),
        .in_decrypt        (in_decrypt),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .last_round_output (last_round_output),
        .round_idx         (round_idx)
    );

    // Reference tables in FIPS numbering (bit 1 = MSB of the word).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
        26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int E_T [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11,
        12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
        22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
    localparam int P_T [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int SHF_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int S_T [8][64] = '{
        '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
          0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
          4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
          15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
        '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
          3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
          0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
          13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
        '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
          13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
          1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
        '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
          13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
          10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
          3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
        '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
          14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
          4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
          11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
        '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
          10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
          9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
          4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
        '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
          13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
          1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
          6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
        '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
          1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
          7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
          2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 1; k <= 64; k++) y[64-k] = x[64-IP_T[k-1]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 1; k <= 64; k++) y[64-IP_T[k-1]] = x[64-k];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int k = 1; k <= 56; k++) y[56-k] = x[64-PC1_T[k-1]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int k = 1; k <= 48; k++) y[48-k] = x[56-PC2_T[k-1]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] key);
        logic [47:0] x;
        logic [5:0]  six;
        logic [31:0] s, y;
        int row, col;
        for (int k = 1; k <= 48; k++) x[48-k] = r[32-E_T[k-1]];
        x = x ^ key;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = {six[5], six[0]};
            col = six[4:1];
            s[31-4*b -: 4] = 4'(S_T[b][row*16+col]);
        end
        for (int k = 1; k <= 32; k++) y[32-k] = s[32-P_T[k-1]];
        return y;
    endfunction

    // Textbook DES: precompute all subkeys, run them reversed for decrypt.
    function automatic logic [63:0] ref_des(input logic [63:0] key, input logic [63:0] blk, input bit dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] ks [16];
        logic [63:0] b;
        logic [31:0] l, r, t;
        cd = pc1_perm(key);
        c = cd[55:28];
        d = cd[27:0];
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < SHF_T[i]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            ks[i] = pc2_perm({c, d});
        end
        b = ip_perm(blk);
        l = b[63:32];
        r = b[31:0];
        for (int i = 0; i < 16; i++) begin
            t = r;
            r = l ^ feistel(r, ks[dec ? 15 - i : i]);
            l = t;
        end
        return fp_perm({r, l});
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[63-i];
        return y;
    endfunction

    function automatic logic [55:0] rev56(input logic [55:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[i] = x[55-i];
        return y;
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_block(input logic [63:0] key, input logic [63:0] blk, input bit dec);
        int i;
        i = 0;
        while (in_ready !== 1'b1 && i < 50) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid   = 1'b1;
        in_block   = rev64(ip_perm(blk));
        in_key     = rev56(pc1_perm(key));
        in_decrypt = dec;
        @(negedge clk);
        in_valid   = 1'b0;
        in_decrypt = ~dec;
        in_block   = {$urandom(), $urandom()};
        in_key     = 56'({$urandom(), $urandom()});
    endtask

    task automatic wait_result(input bit poke, output logic [63:0] raw);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            n_cmp++;
            if (round_idx !== 4'(lat) || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL busy_status: round_idx=%0d in_ready=%b required %0d/0", round_idx, in_ready, lat);
            end
            if (poke && lat >= 2 && lat <= 9) begin
                in_valid   = 1'b1;
                in_block   = {$urandom(), $urandom()};
                in_key     = 56'({$urandom(), $urandom()});
                in_decrypt = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (lat !== 16) begin
            n_err++;
            $display("FAIL latency: got %0d clocks required 16", lat);
        end
        n_cmp++;
        if (round_idx !== 4'd15) begin
            n_err++;
            $display("FAIL done_idx: round_idx=%0d required 15", round_idx);
        end
        raw = last_round_output;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic run_block(input logic [63:0] key, input logic [63:0] blk, input bit dec,
                             input bit poke, output logic [63:0] raw);
        start_block(key, blk, dec);
        wait_result(poke, raw);
        release_result();
    endtask

    task automatic test_reset();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_cmp++;
        if (last_round_output !== 64'd0) begin
            n_err++;
            $display("FAIL reset_output: got %h required 0", last_round_output);
        end
        n_cmp++;
        if (round_idx !== 4'd0) begin n_err++; $display("FAIL reset_round_idx: got %0d required 0", round_idx); end
    endtask

    task automatic test_fips_encrypt();
        logic [63:0] raw;
        run_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, raw);
        n_cmp++;
        if (rev64(raw) !== FIPS_PRE) begin
            n_err++;
            $display("FAIL fips_preoutput: got %h required %h", rev64(raw), FIPS_PRE);
        end
        n_cmp++;
        if (fp_perm(rev64(raw)) !== FIPS_CT) begin
            n_err++;
            $display("FAIL fips_encrypt: got %h required %h", fp_perm(rev64(raw)), FIPS_CT);
        end
    endtask

    task automatic test_fips_decrypt();
        logic [63:0] raw;
        run_block(FIPS_KEY, FIPS_CT, 1'b1, 1'b0, raw);
        n_cmp++;
        if (fp_perm(rev64(raw)) !== FIPS_PT) begin
            n_err++;
            $display("FAIL fips_decrypt: got %h required %h", fp_perm(rev64(raw)), FIPS_PT);
        end
    endtask

    task automatic test_random_roundtrip();
        logic [63:0] key, pt, raw, ct, got, want;
        for (int n = 0; n < 200; n++) begin
            key = {$urandom(), $urandom()};
            pt  = {$urandom(), $urandom()};
            exp_q.push_back(ref_des(key, pt, 1'b0));
            run_block(key, pt, 1'b0, 1'($urandom_range(0, 1)), raw);
            ct   = fp_perm(rev64(raw));
            want = exp_q.pop_front();
            n_cmp++;
            if (ct !== want) begin
                n_err++;
                $display("FAIL rand_encrypt[%0d]: got %h required %h", n, ct, want);
            end
            exp_q.push_back(pt);
            run_block(key, ct, 1'b1, 1'($urandom_range(0, 1)), raw);
            got  = fp_perm(rev64(raw));
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL rand_roundtrip[%0d]: got %h required %h", n, got, want);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] key, pt, held, raw, want;
        key  = {$urandom(), $urandom()};
        pt   = {$urandom(), $urandom()};
        held = rev64(ip_perm(ref_des(key, pt, 1'b0)));
        start_block(key, pt, 1'b0);
        wait_result(1'b0, raw);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_block = {$urandom(), $urandom()};
            n_cmp++;
            if (out_valid !== 1'b1 || last_round_output !== held || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b out=%h required 1/0/%h",
                         i, out_valid, in_ready, last_round_output, held);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_result();
        pt   = {$urandom(), $urandom()};
        want = ref_des(key, pt, 1'b0);
        run_block(key, pt, 1'b0, 1'b0, raw);
        n_cmp++;
        if (fp_perm(rev64(raw)) !== want) begin
            n_err++;
            $display("FAIL bp_next_block: got %h required %h", fp_perm(rev64(raw)), want);
        end
    endtask

    task automatic test_busy_ignore();
        logic [63:0] raw;
        run_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b1, raw);
        n_cmp++;
        if (fp_perm(rev64(raw)) !== FIPS_CT) begin
            n_err++;
            $display("FAIL busy_ignore: got %h required %h", fp_perm(rev64(raw)), FIPS_CT);
        end
    endtask

    task automatic test_mode_latch();
        logic [63:0] key, pt, raw;
        key = {$urandom(), $urandom()};
        pt  = {$urandom(), $urandom()};
        start_block(key, ref_des(key, pt, 1'b0), 1'b1);
        in_decrypt = 1'b0;
        wait_result(1'b0, raw);
        release_result();
        n_cmp++;
        if (fp_perm(rev64(raw)) !== pt) begin
            n_err++;
            $display("FAIL mode_latch: got %h required %h", fp_perm(rev64(raw)), pt);
        end
    endtask

    task automatic test_reset_mid_round();
        logic [63:0] raw;
        int i;
        start_block(FIPS_KEY, FIPS_PT, 1'b0);
        i = 0;
        while (round_idx !== 4'd6 && i < 30) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (round_idx !== 4'd6) begin n_err++; $display("FAIL mid_reach6: round_idx=%0d required 6", round_idx); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || round_idx !== 4'd0 || last_round_output !== 64'd0) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b in_ready=%b round_idx=%0d out=%h required 0/1/0/0",
                     out_valid, in_ready, round_idx, last_round_output);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_partial: out_valid=%b required 0", out_valid); end
        end
        run_block(FIPS_KEY, FIPS_PT, 1'b0, 1'b0, raw);
        n_cmp++;
        if (fp_perm(rev64(raw)) !== FIPS_CT) begin
            n_err++;
            $display("FAIL mid_fresh_block: got %h required %h", fp_perm(rev64(raw)), FIPS_CT);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        in_block   = '0;
        in_key     = '0;
        in_decrypt = 1'b0;
        out_ready  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fips_encrypt();
        test_fips_decrypt();
        test_backpressure();
        test_busy_ignore();
        test_mode_latch();
        test_reset_mid_round();
        test_random_roundtrip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
